// File: rtl/reg_pipe_pkg.sv
// rtl/reg_pipe_pkg.sv - shared constants and sizing helper for the register pipeline
package reg_pipe_pkg;

    localparam int DEFAULT_RESET_VAL = 0;

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// rtl/reg_pipe_stage.sv - one elastic stage: valid bit plus data register
module reg_pipe_stage
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
)
(
    input  logic             clk,
    input  logic             async_reset,
    input  logic             sync_reset,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             rdy,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    // A ready stage always takes the upstream valid bit, so an empty
    // upstream slot propagates forward as a bubble that later words fill.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (sync_reset) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (rdy) begin
            v <= up_valid;
            if (up_valid) begin
                d <= up_data;
            end
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - elastic valid/ready register pipeline with flush and occupancy count
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
)
(
    input  logic                         clk,
    input  logic                         async_reset,
    input  logic                         sync_reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_fire;
    logic             out_fire;

    // Ready ripples from the output end back to the input end.
    always_comb begin
        rdy = '0;
        rdy[DEPTH-1] = !v[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = !v[i] | rdy[i+1];
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic             up_valid;
            logic [WIDTH-1:0] up_data;
            if (i == 0) begin : g_head
                assign up_valid = in_valid;
                assign up_data  = in_data;
            end else begin : g_body
                assign up_valid = v[i-1];
                assign up_data  = d[i-1];
            end
            reg_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk         (clk),
                .async_reset (async_reset),
                .sync_reset  (sync_reset),
                .up_valid    (up_valid),
                .up_data     (up_data),
                .rdy         (rdy[i]),
                .v           (v[i]),
                .d           (d[i])
            );
        end
    endgenerate

    assign in_ready  = rdy[0] & !sync_reset;
    assign out_valid = v[DEPTH-1] & !sync_reset;
    assign out_data  = d[DEPTH-1];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            occupancy <= '0;
        end else if (sync_reset) begin
            occupancy <= '0;
        end else if (in_fire && !out_fire) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_reg_pipe.sv
// tb/tb_reg_pipe.sv - self-checking bench for reg_pipe against a word-queue timing model
module tb_reg_pipe;

    localparam int DEPTH = 4;

    logic       clk;
    logic       async_reset;
    logic       sync_reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] occupancy;

    reg_pipe #(
        .WIDTH     (8),
        .DEPTH     (DEPTH),
        .RESET_VAL (8'h00)
    ) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .sync_reset  (sync_reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    // Model: words in flight in order, each tagged with its entry cycle. The
    // head word reaches the output DEPTH cycles after entry, but never before
    // the cycle following its predecessor's departure.
    typedef struct {
        logic [7:0] data;
        int         entry;
    } word_t;

    word_t q[$];
    int    cyc;
    int    last_fire;
    int    checks;
    int    errors;

    function automatic bit m_in_ready();
        return !sync_reset && ((q.size() < DEPTH) || out_ready);
    endfunction

    function automatic bit m_out_valid();
        int avail;
        if (sync_reset || q.size() == 0) return 1'b0;
        avail = q[0].entry + DEPTH;
        if (last_fire + 1 > avail) avail = last_fire + 1;
        return cyc >= avail;
    endfunction

    task automatic drive(input bit iv, input logic [7:0] id, input bit ordy, input bit sr);
        in_valid   = iv;
        in_data    = id;
        out_ready  = ordy;
        sync_reset = sr;
        #1;
    endtask

    task automatic advance();
        bit inf;
        bit outf;
        inf  = in_valid && m_in_ready();
        outf = m_out_valid() && out_ready;
        @(posedge clk);
        if (sync_reset) begin
            q.delete();
        end else begin
            if (outf) begin
                void'(q.pop_front());
                last_fire = cyc;
            end
            if (inf) q.push_back('{data: in_data, entry: cyc});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        async_reset = 1'b0;
        q.delete();
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_first_fire: in_ready got %b expected 1", in_ready); end
        advance();
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        advance();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL reset_two_held: occupancy got %0d expected 2", occupancy); end
        #1 async_reset = 1'b1;
        #1;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL async_occupancy: got %0d expected 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL async_out_data: got %h expected 00", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready: got %b expected 1", in_ready); end
        async_reset = 1'b0;
        q.delete();
        advance();
    endtask

    task automatic test_stream();
        int         first_out = -1;
        int         last_out  = -1;
        int         n_out     = 0;
        logic [7:0] nxt       = 8'h01;
        for (int t = 0; t < 20; t++) begin
            drive(t < 8, 8'(t + 1), 1'b1, 1'b0);
            checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL stream_in_ready t=%0d: got %b expected %b", t, in_ready, m_in_ready()); end
            checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL stream_out_valid t=%0d: got %b expected %b", t, out_valid, m_out_valid()); end
            checks++; if (occupancy !== 3'(q.size())) begin errors++; $display("FAIL stream_occupancy t=%0d: got %0d expected %0d", t, occupancy, q.size()); end
            if (out_valid && out_ready) begin
                if (first_out < 0) first_out = t;
                last_out = t;
                n_out++;
                checks++; if (out_data !== nxt) begin errors++; $display("FAIL stream_data t=%0d: got %h expected %h", t, out_data, nxt); end
                nxt++;
            end
            advance();
        end
        checks++; if (first_out !== DEPTH) begin errors++; $display("FAIL stream_latency: first out at %0d expected %0d", first_out, DEPTH); end
        checks++; if (n_out !== 8 || last_out - first_out !== 7) begin errors++; $display("FAIL stream_gapless: %0d words over span %0d expected 8 over 7", n_out, last_out - first_out); end
    endtask

    task automatic test_backpressure();
        int         idx = 0;
        logic [7:0] nxt = 8'hA0;
        bit         ordy;
        for (int t = 0; t < 20; t++) begin
            ordy = (t >= 8);
            drive(idx < 5, 8'(8'hA0 + idx), ordy, 1'b0);
            if (t == 4) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready: got %b expected 0", in_ready); end
                checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_full_occupancy: got %0d expected 4", occupancy); end
            end
            if (t == 8) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_a4_accept: in_ready got %b expected 1", in_ready); end
            end
            checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL bp_in_ready t=%0d: got %b expected %b", t, in_ready, m_in_ready()); end
            checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL bp_out_valid t=%0d: got %b expected %b", t, out_valid, m_out_valid()); end
            if (out_valid && out_ready) begin
                checks++; if (out_data !== nxt) begin errors++; $display("FAIL bp_data t=%0d: got %h expected %h", t, out_data, nxt); end
                nxt++;
            end
            if (in_valid && m_in_ready()) idx++;
            advance();
        end
        checks++; if (nxt !== 8'hA5) begin errors++; $display("FAIL bp_count: next expected word %h, should be A5", nxt); end
    endtask

    task automatic test_bubble();
        for (int t = 0; t < 17; t++) begin
            drive(t == 0 || t == 7, (t == 0) ? 8'h11 : 8'h22, t >= 12, 1'b0);
            if (t == 11) begin
                checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL bubble_occupancy: got %0d expected 2", occupancy); end
                checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL bubble_head: got %b/%h expected 1/11", out_valid, out_data); end
            end
            if (t == 13) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin errors++; $display("FAIL bubble_collapsed: got %b/%h expected 1/22", out_valid, out_data); end
            end
            checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL bubble_out_valid t=%0d: got %b expected %b", t, out_valid, m_out_valid()); end
            checks++; if (occupancy !== 3'(q.size())) begin errors++; $display("FAIL bubble_occ t=%0d: got %0d expected %0d", t, occupancy, q.size()); end
            advance();
        end
    endtask

    task automatic test_sync_reset();
        for (int t = 0; t < 6; t++) begin
            drive(t < 3, 8'(8'hC0 + t), 1'b0, 1'b0);
            advance();
        end
        drive(1'b1, 8'hEE, 1'b1, 1'b1);
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 3", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        advance();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_post_occ: got %0d expected 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_post_valid: got %b expected 0", out_valid); end
        advance();
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 24; t++) begin
            drive(t < 14, 8'(8'h30 + t), t >= 4, 1'b0);
            if (t >= 4 && t < 14) begin
                checks++; if (occupancy !== 3'd4 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
                    errors++; $display("FAIL b2b_full t=%0d: occ/in_ready/out_valid %0d/%b/%b expected 4/1/1", t, occupancy, in_ready, out_valid);
                end
            end
            checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL b2b_out_valid t=%0d: got %b expected %b", t, out_valid, m_out_valid()); end
            if (out_valid && q.size() > 0) begin
                checks++; if (out_data !== q[0].data) begin errors++; $display("FAIL b2b_data t=%0d: got %h expected %h", t, out_data, q[0].data); end
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
            checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL rand_in_ready t=%0d: got %b expected %b", t, in_ready, m_in_ready()); end
            checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL rand_out_valid t=%0d: got %b expected %b", t, out_valid, m_out_valid()); end
            checks++; if (occupancy !== 3'(q.size())) begin errors++; $display("FAIL rand_occupancy t=%0d: got %0d expected %0d", t, occupancy, q.size()); end
            if (m_out_valid()) begin
                checks++; if (out_data !== q[0].data) begin errors++; $display("FAIL rand_data t=%0d: got %h expected %h", t, out_data, q[0].data); end
            end
            advance();
        end
        for (int t = 0; t < 20 && q.size() > 0; t++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            advance();
        end
        checks++; if (occupancy !== 3'd0 || q.size() != 0) begin errors++; $display("FAIL rand_drain: occupancy %0d, model holds %0d, expected both 0", occupancy, q.size()); end
    endtask

    initial begin
        clk         = 1'b0;
        async_reset = 1'b1;
        sync_reset  = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_data     = 8'h00;
        cyc         = 0;
        last_fire   = -1000;
        checks      = 0;
        errors      = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_sync_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
